// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Writer side of the instruction-memory port. It receives a byte stream
//   framed as a 16-bit word count N (MSB first) followed by 4*N bytes. Each
//   group of 4 bytes becomes one big-endian word, written at word addresses
//   0, 1, ... N-1. The CPU is held at its reset vector until a load
//   finishes successfully.
//
// Ports
//   clk, rst_n              system clock, asynchronous active-low reset
//   start                   one-cycle pulse that begins a load from IDLE/DONE/ERR
//   in_valid, in_data       byte source
//   in_ready                loader accepts in_data this cycle
//   imem_we/addr/wdata      instruction memory write port (one pulse per word)
//   cpu_hold                hold the CPU PC at its reset vector
//   loaded                  last load succeeded (DONE)
//   err                     last frame's word count exceeded the memory depth (ERR)
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | after reset, waiting for start
// LEN_HI  | waiting for word-count byte 15:8
// LEN_LO  | waiting for word-count byte 7:0, then range check
// DATA    | collecting the 4 bytes of the current word
// WRITE   | one-cycle memory write of the assembled word
// DONE    | load complete, CPU released
// ERR     | word count too large, nothing written, CPU held
module instr_mem_loader #(
    parameter int ADDR_W           = 8,
    parameter bit HOLD_AFTER_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              loaded,
    output logic              err
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t state, state_nxt;

    logic        xfer;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [15:0] len_full;
    logic [15:0] wr_cnt;
    logic [1:0]  byte_idx;
    logic [23:0] shift;
    logic        last_word;
    logic        len_too_big;

    assign xfer        = in_valid && in_ready;
    assign len_full    = {len_hi, in_data};
    assign len_too_big = {16'd0, len_full} > DEPTH;
    // wr_cnt counts words already written before the current WRITE cycle.
    assign last_word   = (wr_cnt + 16'd1) == len;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_LEN_HI;
            S_LEN_HI: if (xfer) state_nxt = S_LEN_LO;
            S_LEN_LO: begin
                if (xfer) begin
                    if (len_full == 16'd0) state_nxt = S_DONE;
                    else if (len_too_big)  state_nxt = S_ERR;
                    else                   state_nxt = S_DATA;
                end
            end
            S_DATA:  if (xfer && byte_idx == 2'd3) state_nxt = S_WRITE;
            S_WRITE: state_nxt = last_word ? S_DONE : S_DATA;
            default: state_nxt = S_IDLE;
        endcase
    end

    // outputs decoded from state
    always_comb begin
        in_ready = 1'b0;
        imem_we  = 1'b0;
        loaded   = 1'b0;
        err      = 1'b0;
        cpu_hold = 1'b1;
        case (state)
            S_IDLE:                   cpu_hold = HOLD_AFTER_RESET;
            S_LEN_HI, S_LEN_LO, S_DATA: in_ready = 1'b1;
            S_WRITE:                  imem_we  = 1'b1;
            S_DONE: begin
                loaded   = 1'b1;
                cpu_hold = 1'b0;
            end
            S_ERR:                    err      = 1'b1;
            default:                  cpu_hold = 1'b1;
        endcase
    end

    // datapath: length, byte assembly, address and word counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_hi     <= 8'd0;
            len        <= 16'd0;
            wr_cnt     <= 16'd0;
            byte_idx   <= 2'd0;
            shift      <= 24'd0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
        end else begin
            case (state)
                S_LEN_HI: if (xfer) len_hi <= in_data;
                S_LEN_LO: begin
                    if (xfer) begin
                        len <= len_full;
                        // address restarts only for a frame that will write;
                        // an empty or rejected frame leaves the last address
                        if (state_nxt == S_DATA) begin
                            byte_idx  <= 2'd0;
                            wr_cnt    <= 16'd0;
                            imem_addr <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        byte_idx <= byte_idx + 2'd1;
                        shift    <= {shift[15:0], in_data};
                        if (byte_idx == 2'd3) imem_wdata <= {shift, in_data};
                    end
                end
                S_WRITE: begin
                    wr_cnt <= wr_cnt + 16'd1;
                    // no increment after the last word so N=DEPTH ends at DEPTH-1
                    if (!last_word) imem_addr <= imem_addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer side of the instruction-memory interface that the single-cycle CPU fetches from.
- Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words and writes them sequentially into instruction memory from word address 0.
- Holds the CPU via cpu_hold until a load completes.
- Sits between the host/UART byte source and the instruction memory write port, alongside the CPU top.

Parameters:
ADDR_W, 8, instruction memory word-address width; capacity DEPTH = 2^ADDR_W words.
HOLD_AFTER_RESET, 1, value of cpu_hold while in IDLE after reset (1 = CPU held until first load completes).

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  single-cycle pulse; begins a load session when in IDLE, DONE or ERR
in_valid  input  1  byte source has in_data available
in_data  input  8  stream byte
in_ready  output  1  loader accepts in_data this cycle
imem_we  output  1  instruction memory write enable, one-cycle pulse per word
imem_addr  output  ADDR_W  word address for the write
imem_wdata  output  32  assembled instruction word
cpu_hold  output  1  hold CPU PC at reset vector while high
loaded  output  1  high in DONE: last load succeeded
err  output  1  high in ERR: word count exceeded DEPTH

Behaviour:
- Reset (async, rst_n=0): state=IDLE. in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, loaded=0, err=0, cpu_hold=HOLD_AFTER_RESET, internal count/byte index cleared. Reset mid-session abandons the load immediately; no partial write completes.
- Byte transfer occurs only on a cycle where in_valid && in_ready. in_data is ignored otherwise.
- Frame format: 2 length bytes (word count N, 16-bit, MSB first), then 4*N data bytes, each word MSB first (first byte -> bits 31:24).
- States:
  - IDLE: in_ready=0. start -> LEN_HI; cpu_hold=1.
  - LEN_HI: in_ready=1. On transfer, latch N[15:8] -> LEN_LO.
  - LEN_LO: in_ready=1. On transfer, latch N[7:0], then:
    - N=0 -> DONE
    - N>DEPTH -> ERR
    - else -> DATA, with byte index=0 and imem_addr=0.
  - DATA: in_ready=1. Each transfer shifts the byte into the word register. On the 4th byte -> WRITE.
  - WRITE: exactly one cycle. imem_we=1, imem_wdata=assembled word, imem_addr=current address, in_ready=0 (one-cycle bubble per word). Next cycle:
    - if words written == N -> DONE
    - else imem_addr+1 -> DATA.
  - DONE: loaded=1, cpu_hold=0, in_ready=0. start -> LEN_HI, clears loaded and sets cpu_hold=1 in the same edge.
  - ERR: err=1, cpu_hold=1, in_ready=0, memory not written. start -> LEN_HI, clears err.
- start in LEN_HI/LEN_LO/DATA/WRITE is ignored (no restart mid-session).
- N=DEPTH is legal: the last write is at address DEPTH-1, and imem_addr does not wrap before DONE. imem_addr holds its last written value in DONE.
- imem_wdata holds its last value when imem_we=0. Memory samples imem_* on the rising edge where imem_we=1.
- Minimum load time with a continuous source: 2 + 5*N cycles from the first accepted byte to entering DONE.
- Source stalls (in_valid=0) are allowed in any accepting state, for any length. Assembly resumes with no byte lost or duplicated.

Test Plan:
- Reset, then start; stream 00 02 | 24 08 00 05 | AC 08 00 04 with in_valid always 1 -> writes 0x24080005 @0 and 0xAC080004 @1, one imem_we pulse each, in_ready low on both WRITE cycles; loaded=1, cpu_hold=0 exactly 12 cycles after the first accepted byte.
- Same frame with in_valid dropped for 3 cycles after every data byte -> identical writes and addresses; only the timing differs.
- start, then 00 00 -> DONE directly, no imem_we, loaded=1, cpu_hold=0.
- ADDR_W=8, length 01 01 (257) -> ERR, err=1, cpu_hold=1, in_ready=0, no writes; then start plus a valid 1-word frame -> err=0, one write @0, loaded=1.
- Mid-DATA (2 of 4 bytes of word 1 sent), pulse start -> ignored, word completes normally. Then assert rst_n=0 during the next word -> all outputs return to reset values asynchronously, no write issued for the partial word.
- After a successful load, start a new frame 00 01 | 00 00 00 0C -> loaded drops and cpu_hold rises on the start edge; single write of 0x0000000C @0; DONE again.
